fifo_wr_ptr_ctrl: RTL and testbench

Write-domain pointer controller for the asynchronous FIFO. It is the producer side of the flag logic.
- Advances the write pointer on accepted writes and drives memory write enable and address.
- Publishes a registered Gray-coded write pointer for the read domain.
- Synchronises the read domain's Gray pointer into the write clock and converts it to binary plus wrap MSB, which the flag logic consumes as b_rd_ptr_sync / MSB_rd_ptr.

---
 rtl/fifo_ptr_pkg.sv | 27 ++
 rtl/gray_ptr_sync_2ff.sv | 31 +++
 rtl/fifo_wr_ptr_ctrl.sv | 68 ++++++
 tb/tb_fifo_wr_ptr_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared pointer constants and Gray-code helpers for the async FIFO pointer controllers.
// The helpers work on a wide word, so callers size-cast to their own pointer width.
package fifo_ptr_pkg;

  localparam int ADDR_WIDTH_DFLT = 4;
  localparam int PTR_W           = ADDR_WIDTH_DFLT + 1;
  localparam int GRAY_MAX_W      = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;
  typedef logic [PTR_W-1:0]      ptr_t;

  function automatic gray_word_t bin2gray(input gray_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
  // Zero-extended upper bits contribute nothing, so narrower pointers convert correctly.
  function automatic gray_word_t gray2bin(input gray_word_t gray);
    gray_word_t bin;
    bin = gray;
    for (int i = 1; i < GRAY_MAX_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer from the other clock domain,
// followed by Gray-to-binary conversion in the receiving domain.
module gray_ptr_sync_2ff
  import fifo_ptr_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] gray_async,
  output logic [W-1:0] bin_sync
);

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;

  // NOTE: sequential state uses non-blocking assignments so sync1 -> sync2 forms a
  // real two-stage shift; blocking here would collapse both stages into one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gray_async;
      sync2 <= sync1;
    end
  end

  assign bin_sync = W'(gray2bin(GRAY_MAX_W'(sync2)));

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer controller: advances the write pointer, drives the RAM write port,
// publishes a registered Gray pointer and brings the read pointer into this clock domain.
module fifo_wr_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  f_full,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] b_wr_ptr,
  output logic                  MSB_wr_ptr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] b_rd_ptr_sync,
  output logic                  MSB_rd_ptr_sync,
  output logic                  wr_overflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic          accept;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_inc;
  logic [PW-1:0] rd_ptr_bin;

  // Gating with reset keeps mem_we low for the whole reset pulse, not just after the flops clear.
  assign accept     = wr_en & ~f_full & ~reset;
  assign wr_ptr_inc = wr_ptr + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      wr_ptr_gray <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr      <= wr_ptr_inc;
        // Registered straight from the next-pointer value so the crossing sees a clean flop output.
        wr_ptr_gray <= PW'(bin2gray(GRAY_MAX_W'(wr_ptr_inc)));
      end
      if (wr_en && f_full) begin
        wr_overflow <= 1'b1;
      end
    end
  end

  assign mem_we     = accept;
  assign wr_addr    = wr_ptr[ADDR_WIDTH-1:0];
  assign b_wr_ptr   = wr_ptr[ADDR_WIDTH-1:0];
  assign MSB_wr_ptr = wr_ptr[ADDR_WIDTH];

  gray_ptr_sync_2ff #(
    .W (PW)
  ) u_rd_ptr_sync (
    .clk        (clk),
    .reset      (reset),
    .gray_async (rd_ptr_gray_async),
    .bin_sync   (rd_ptr_bin)
  );

  assign b_rd_ptr_sync   = rd_ptr_bin[ADDR_WIDTH-1:0];
  assign MSB_rd_ptr_sync = rd_ptr_bin[ADDR_WIDTH];

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Self-checking bench for fifo_wr_ptr_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a count-based behavioural model.
module tb_fifo_wr_ptr_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          f_full;
  logic [AW:0]   rd_ptr_gray_async;
  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] b_wr_ptr;
  logic          MSB_wr_ptr;
  logic [AW:0]   wr_ptr_gray;
  logic [AW-1:0] b_rd_ptr_sync;
  logic          MSB_rd_ptr_sync;
  logic          wr_overflow;

  fifo_wr_ptr_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .wr_en             (wr_en),
    .f_full            (f_full),
    .rd_ptr_gray_async (rd_ptr_gray_async),
    .mem_we            (mem_we),
    .wr_addr           (wr_addr),
    .b_wr_ptr          (b_wr_ptr),
    .MSB_wr_ptr        (MSB_wr_ptr),
    .wr_ptr_gray       (wr_ptr_gray),
    .b_rd_ptr_sync     (b_rd_ptr_sync),
    .MSB_rd_ptr_sync   (MSB_rd_ptr_sync),
    .wr_overflow       (wr_overflow)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit run_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: Gray code by definition, inverse by exhaustive search.
  function automatic int to_gray(input int v);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input int g);
    for (int b = 0; b < 2 * DEPTH; b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  // Behavioural model: number of accepted writes, sticky error, history of sampled read pointers.
  int     m_writes;
  bit     m_ovf;
  int     m_rd_hist[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_writes  = 0;
      m_ovf     = 1'b0;
      m_rd_hist = '{0, 0};
    end else begin
      if (wr_en && !f_full) m_writes = (m_writes + 1) % (2 * DEPTH);
      if (wr_en && f_full)  m_ovf = 1'b1;
      m_rd_hist.push_back(int'(rd_ptr_gray_async));
      void'(m_rd_hist.pop_front());
    end
  end

  // Compare process: every falling edge outside reset.
  logic [AW:0] prev_gray = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_gray <= '0;
    end else if (run_chk) begin
      int rd_bin;
      rd_bin = from_gray(m_rd_hist[0]);
      check("mem_we",      32'(mem_we),          32'(wr_en & ~f_full));
      check("wr_addr",     32'(wr_addr),         32'(m_writes % DEPTH));
      check("b_wr_ptr",    32'(b_wr_ptr),        32'(m_writes % DEPTH));
      check("MSB_wr_ptr",  32'(MSB_wr_ptr),      32'(m_writes / DEPTH));
      check("wr_ptr_gray", 32'(wr_ptr_gray),     32'(to_gray(m_writes)));
      check("b_rd_sync",   32'(b_rd_ptr_sync),   32'(rd_bin % DEPTH));
      check("MSB_rd_sync", 32'(MSB_rd_ptr_sync), 32'(rd_bin / DEPTH));
      check("wr_overflow", 32'(wr_overflow),     32'(m_ovf));
      check("gray_1bit",   32'($countones(prev_gray ^ wr_ptr_gray) <= 1), 32'd1);
      prev_gray <= wr_ptr_gray;
    end
  end

  task automatic drive(input logic we, input logic ff, input logic [AW:0] rg);
    @(posedge clk);
    #1;
    wr_en             = we;
    f_full            = ff;
    rd_ptr_gray_async = rg;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_mem_we"},   32'(mem_we),          32'd0);
    check({tag, "_wr_addr"},  32'(wr_addr),         32'd0);
    check({tag, "_b_wr"},     32'(b_wr_ptr),        32'd0);
    check({tag, "_msb_wr"},   32'(MSB_wr_ptr),      32'd0);
    check({tag, "_gray"},     32'(wr_ptr_gray),     32'd0);
    check({tag, "_b_rd"},     32'(b_rd_ptr_sync),   32'd0);
    check({tag, "_msb_rd"},   32'(MSB_rd_ptr_sync), 32'd0);
    check({tag, "_ovf"},      32'(wr_overflow),     32'd0);
  endtask

  // Asynchronous reset pulse with random inputs; outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #1;
    reset             = 1'b1;
    wr_en             = 1'b1;
    f_full            = 1'($urandom);
    rd_ptr_gray_async = (AW+1)'($urandom);
    #1;
    chk_zero(tag);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset             = 1'b0;
    wr_en             = 1'b0;
    f_full            = 1'b0;
    rd_ptr_gray_async = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    reset             = 1'b1;
    wr_en             = 1'b0;
    f_full            = 1'b0;
    rd_ptr_gray_async = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("por");
    reset   = 1'b0;
    run_chk = 1'b1;

    do_reset("rst1");

    // Five consecutive writes land on addresses 0..4.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, '0);
      #1;
      check("t2_mem_we", 32'(mem_we), 32'd1);
      check("t2_addr",   32'(wr_addr), 32'(k));
    end
    drive(1'b0, 1'b0, '0);
    #1;
    check("t2_b_wr",  32'(b_wr_ptr),    32'd5);
    check("t2_msb",   32'(MSB_wr_ptr),  32'd0);
    check("t2_gray",  32'(wr_ptr_gray), 32'b00111);

    // Wrap: 16 writes toggle the MSB, 32 writes return to zero.
    do_reset("rst3");
    repeat (16) drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    #1;
    check("t3_b_wr16", 32'(b_wr_ptr),    32'd0);
    check("t3_msb16",  32'(MSB_wr_ptr),  32'd1);
    check("t3_gray16", 32'(wr_ptr_gray), 32'b11000);
    repeat (16) drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    #1;
    check("t3_b_wr32", 32'(b_wr_ptr),    32'd0);
    check("t3_msb32",  32'(MSB_wr_ptr),  32'd0);
    check("t3_gray32", 32'(wr_ptr_gray), 32'd0);

    // Write while full is dropped and latches the sticky error.
    drive(1'b1, 1'b1, '0);
    #1;
    check("t4_mem_we", 32'(mem_we), 32'd0);
    drive(1'b0, 1'b0, '0);
    #1;
    check("t4_b_wr", 32'(b_wr_ptr),    32'd0);
    check("t4_ovf",  32'(wr_overflow), 32'd1);
    repeat (3) drive(1'b0, 1'b0, '0);
    #1;
    check("t4_ovf_hold", 32'(wr_overflow), 32'd1);

    // Read pointer synchroniser latency: two edges.
    drive(1'b0, 1'b0, 5'b01101);
    drive(1'b0, 1'b0, 5'b01101);
    #1;
    check("t5_edge1", 32'(b_rd_ptr_sync), 32'd0);
    drive(1'b0, 1'b0, 5'b01101);
    #1;
    check("t5_b_rd9",  32'(b_rd_ptr_sync),   32'd9);
    check("t5_msb_rd", 32'(MSB_rd_ptr_sync), 32'd0);
    drive(1'b0, 1'b0, 5'b10101);  // Gray code of binary 25
    drive(1'b0, 1'b0, 5'b10101);
    #1;
    check("t5_hold_b",   32'(b_rd_ptr_sync),   32'd9);
    check("t5_hold_msb", 32'(MSB_rd_ptr_sync), 32'd0);
    drive(1'b0, 1'b0, 5'b10101);
    #1;
    check("t5_b_rd25",  32'(b_rd_ptr_sync),   32'd9);
    check("t5_msb_rd1", 32'(MSB_rd_ptr_sync), 32'd1);

    // Reset mid-burst at pointer 7; first write afterwards goes to address 0.
    do_reset("rst6a");
    repeat (8) drive(1'b1, 1'b0, '0);
    #1;
    check("t6_b_wr7", 32'(b_wr_ptr), 32'd7);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("t6_mid");
    @(negedge clk);
    drive(1'b1, 1'b0, '0);
    reset = 1'b0;
    #1;
    check("t6_mem_we", 32'(mem_we),  32'd1);
    check("t6_addr0",  32'(wr_addr), 32'd0);
    drive(1'b0, 1'b0, '0);

    // Randomized traffic against the model, with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset("rst_rand");
      drive(($urandom % 4) != 0, ($urandom % 4) == 0, (AW+1)'($urandom));
    end
    repeat (3) drive(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
